// File: rtl/serial_frame_pkg.sv
// Shared width and state encodings for the serial frame link.
// Optional parity support is selected with SERIAL_FRAME_PARITY_EN.
package serial_frame_pkg;

  localparam int DATA_W = 162;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/serial_frame_rx.sv
// Receiver: 2-flop line synchronizer plus frame FSM that rebuilds the word.
// SERIAL_FRAME_PARITY_EN adds an even-parity bit check before the stop bit.
//
// state        | meaning
// RX_IDLE      | line idle, waiting for a low level
// RX_START     | half-bit wait, confirm start bit is still low
// RX_DATA      | sample one payload bit per bit time, LSB first
// RX_PARITY    | sample parity bit (parity build only)
// RX_STOP      | sample stop bit, publish word or flag error
// RX_WAIT_IDLE | line stuck low after a bad stop, wait for high
import serial_frame_pkg::*;

module serial_frame_rx #(
  parameter int DATA_W       = serial_frame_pkg::DATA_W,
  parameter int CLKS_PER_BIT = 10000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_IDX    = BW'(DATA_W - 1);

  logic [1:0]        sync_q;
  logic              s_rx;
  rx_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_q, ready_d;
  logic              ferr_q, ferr_d;
  logic              par_ok;

  // Sync flops idle high so reset never looks like a start bit
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], rx_in};
  end

  assign s_rx = sync_q[1];

`ifdef SERIAL_FRAME_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) par_q <= 1'b0;
    else         par_q <= par_d;
  end

  assign par_ok = ~(^shift_q ^ par_q);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      RX_IDLE: begin
        if (!s_rx) begin
          state_d = RX_START;
          cnt_d   = HALF_RELOAD;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (!s_rx) begin
            state_d = RX_DATA;
            cnt_d   = BIT_RELOAD;
            bit_d   = LAST_IDX;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {s_rx, shift_q[DATA_W-1:1]};
          cnt_d   = BIT_RELOAD;
          if (bit_q == '0) begin
`ifdef SERIAL_FRAME_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end else begin
            bit_d = bit_q - BW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef SERIAL_FRAME_PARITY_EN
      RX_PARITY: begin
        if (cnt_q == '0) begin
          par_d   = s_rx;
          cnt_d   = BIT_RELOAD;
          state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      RX_STOP: begin
        if (cnt_q == '0) begin
          if (s_rx && par_ok) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = s_rx ? RX_IDLE : RX_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_WAIT_IDLE: begin
        if (s_rx) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data_out  = data_q;
  assign ready     = ready_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/serial_frame_link.sv
// Serial frame link top: inline UART-like transmitter plus serial_frame_rx.
// SERIAL_FRAME_PARITY_EN inserts an even-parity bit after the payload.
//
// state     | meaning
// TX_IDLE   | line high, waiting for trigger_in
// TX_START  | drive start bit (low) for one bit time
// TX_DATA   | drive payload LSB first, one bit per bit time
// TX_PARITY | drive even-parity bit (parity build only)
// TX_STOP   | drive stop bit (high) for one bit time
import serial_frame_pkg::*;

module serial_frame_link #(
  parameter int DATA_W       = serial_frame_pkg::DATA_W,
  parameter int CLKS_PER_BIT = 10000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              trigger_in,
  input  logic [DATA_W-1:0] val_in,
  output logic              tx_out,
  output logic              tx_busy,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_IDX   = BW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

`ifdef SERIAL_FRAME_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) par_q <= 1'b0;
    else         par_q <= par_d;
  end
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // tx_d is the line level for the state being entered, so tx_out is a pure flop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
`ifdef SERIAL_FRAME_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      TX_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (trigger_in) begin
          state_d = TX_START;
          shift_d = val_in;
          cnt_d   = BIT_RELOAD;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
`ifdef SERIAL_FRAME_PARITY_EN
          par_d   = ^val_in;
`endif
        end
      end
      TX_START: begin
        if (cnt_q == '0) begin
          state_d = TX_DATA;
          cnt_d   = BIT_RELOAD;
          bit_d   = LAST_IDX;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TX_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BIT_RELOAD;
          if (bit_q == '0) begin
`ifdef SERIAL_FRAME_PARITY_EN
            state_d = TX_PARITY;
            tx_d    = par_q;
`else
            state_d = TX_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d = {1'b0, shift_q[DATA_W-1:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q - BW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef SERIAL_FRAME_PARITY_EN
      TX_PARITY: begin
        if (cnt_q == '0) begin
          state_d = TX_STOP;
          cnt_d   = BIT_RELOAD;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      TX_STOP: begin
        if (cnt_q == '0) begin
          state_d = TX_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx_out  = tx_q;
  assign tx_busy = busy_q;

  serial_frame_rx #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rx_in    (rx_in),
    .data_out (data_out),
    .ready    (ready),
    .frame_err(frame_err)
  );

endmodule

// File: tb/tb_serial_frame_link.sv
// Loopback bench for serial_frame_link with a queue scoreboard of sent words.
import serial_frame_pkg::*;

module tb_serial_frame_link;

  localparam int CPB = 16;
`ifdef SERIAL_FRAME_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 3;
`else
  localparam int FRAME_BITS = DATA_W + 2;
`endif

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic              trigger_in = 1'b0;
  logic [DATA_W-1:0] val_in = '0;
  logic              tx_out, tx_busy;
  logic              rx_in;
  logic [DATA_W-1:0] data_out;
  logic              ready, frame_err;
  logic              rx_force = 1'b0;

  assign rx_in = rx_force ? 1'b0 : tx_out;

  always #5 clk_in = ~clk_in;

  serial_frame_link #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .trigger_in(trigger_in),
    .val_in    (val_in),
    .tx_out    (tx_out),
    .tx_busy   (tx_busy),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .ready     (ready),
    .frame_err (frame_err)
  );

  int n_total = 0;
  int n_bad   = 0;
  int ready_cnt = 0;
  int ferr_cnt  = 0;
  logic [DATA_W-1:0] sb_q[$];

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (ready) begin
      ready_cnt++;
      check("ready_expected", DATA_W'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) check("rx_word", data_out, sb_q.pop_front());
    end
    if (frame_err) ferr_cnt++;
  end

  // Caller is at a negedge; trigger is sampled on the following posedge.
  task automatic send(input logic [DATA_W-1:0] w, input bit expect_rx);
    trigger_in = 1'b1;
    val_in     = w;
    if (expect_rx) sb_q.push_back(w);
    @(negedge clk_in);
    trigger_in = 1'b0;
  endtask

  task automatic wait_tx_done(output int cyc);
    int g;
    g   = 0;
    cyc = tx_busy ? 1 : 0;
    while (tx_busy && g < 4 * FRAME_BITS * CPB) begin
      @(negedge clk_in);
      if (tx_busy) cyc++;
      g++;
    end
    check("tx_done_timeout", DATA_W'(tx_busy), 0);
  endtask

  task automatic wait_ready(input int target);
    int g;
    g = 0;
    while (ready_cnt < target && g < 4 * FRAME_BITS * CPB) begin
      @(negedge clk_in);
      g++;
    end
    check("ready_arrived", DATA_W'(ready_cnt >= target), 1);
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < 6; i++) w = {w[DATA_W-33:0], 32'($urandom)};
    return w;
  endfunction

  initial begin
    int cyc, low_cnt, r0, f0;
    logic [DATA_W-1:0] w_a, w_ones, w_junk, w_fresh;
    w_a    = 162'h2_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    w_ones = '1;
    w_junk = 162'h1_5555_0000_1234_5678_9ABC_DEF0_0F0F_F0F0_3C3C_C3C3;

    #100;
    @(negedge clk_in);
    rst_in = 1'b1;
    check("rst_tx_out", DATA_W'(tx_out), 1);
    check("rst_tx_busy", DATA_W'(tx_busy), 0);
    check("rst_data_out", data_out, 0);
    check("rst_ready", DATA_W'(ready), 0);

    low_cnt = 0;
    repeat (5000) begin
      @(negedge clk_in);
      if (!tx_out || tx_busy) low_cnt++;
    end
    check("idle_tx_quiet", DATA_W'(low_cnt), 0);
    check("idle_ready_cnt", DATA_W'(ready_cnt), 0);
    check("idle_ferr_cnt", DATA_W'(ferr_cnt), 0);

    // single alternating word, busy length is the whole frame
    send(w_a, 1'b1);
    wait_tx_done(cyc);
    check("busy_cycles_a", DATA_W'(cyc), DATA_W'(FRAME_BITS * CPB));
    wait_ready(1);
    repeat (100) @(negedge clk_in);
    check("ready_cnt_a", DATA_W'(ready_cnt), 1);
    check("data_hold_a", data_out, w_a);

    // trigger mid-frame is dropped; back-to-back accepted on first idle cycle
    send(162'h1, 1'b1);
    repeat (500) @(negedge clk_in);
    send(w_junk, 1'b0);
    wait_tx_done(cyc);
    send(w_ones, 1'b1);
    check("b2b_accept", DATA_W'(tx_busy), 1);
    wait_tx_done(cyc);
    check("busy_cycles_ones", DATA_W'(cyc), DATA_W'(FRAME_BITS * CPB));
    wait_ready(3);
    repeat (100) @(negedge clk_in);
    check("ready_cnt_b2b", DATA_W'(ready_cnt), 3);
    check("data_hold_ones", data_out, w_ones);

    // short low glitch while idle
    r0 = ready_cnt;
    f0 = ferr_cnt;
    rx_force = 1'b1;
    repeat (5) @(negedge clk_in);
    rx_force = 1'b0;
    repeat (300) @(negedge clk_in);
    check("glitch_no_ready", DATA_W'(ready_cnt - r0), 0);
    check("glitch_no_ferr", DATA_W'(ferr_cnt - f0), 0);

    // stop bit forced low
    r0 = ready_cnt;
    f0 = ferr_cnt;
    send(w_junk, 1'b0);
    repeat ((FRAME_BITS - 1) * CPB - 1) @(negedge clk_in);
    rx_force = 1'b1;
    repeat (24) @(negedge clk_in);
    rx_force = 1'b0;
    wait_tx_done(cyc);
    repeat (100) @(negedge clk_in);
    check("stop_err_ferr", DATA_W'(ferr_cnt - f0), 1);
    check("stop_err_no_ready", DATA_W'(ready_cnt - r0), 0);
    check("stop_err_data_kept", data_out, w_ones);

    // reset in the middle of data bit 80
    r0 = ready_cnt;
    send(w_a, 1'b0);
    repeat (81 * CPB) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("midrst_tx_out", DATA_W'(tx_out), 1);
    check("midrst_tx_busy", DATA_W'(tx_busy), 0);
    check("midrst_data_out", data_out, 0);
    repeat (5) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (3000) @(negedge clk_in);
    check("midrst_no_ready", DATA_W'(ready_cnt - r0), 0);
    check("midrst_line_idle", DATA_W'(tx_out), 1);

    w_fresh = rand_word();
    send(w_fresh, 1'b1);
    wait_tx_done(cyc);
    wait_ready(r0 + 1);
    repeat (50) @(negedge clk_in);
    check("fresh_data_hold", data_out, w_fresh);
    check("sb_drained", DATA_W'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
